// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter: round-robin burst arbiter feeding one FIFO write port. Rev 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DataWidth = 16,
  parameter int NumReq    = 4,
  parameter int MaxBurst  = 4
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic [NumReq*DataWidth-1:0]     req_data_i,
  input  logic [NumReq-1:0]               req_val_i,
  output logic [NumReq-1:0]               req_rdy_o,
  output logic [DataWidth-1:0]            fifo_din_o,
  output logic                            fifo_din_val_o,
  input  logic                            fifo_din_rdy_i,
  output logic [NumReq-1:0]               grant_o,
  output logic [$clog2(NumReq)-1:0]       grant_id_o,
  output logic [$clog2(MaxBurst+1)-1:0]   beat_cnt_o
);

  localparam int ID_W  = $clog2(NumReq);
  localparam int CNT_W = $clog2(MaxBurst+1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MaxBurst - 1);
  localparam logic [ID_W-1:0]  RST_LAST  = ID_W'(NumReq - 1);

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             granted;
  logic             beat;
  logic             rr_found;
  logic [ID_W-1:0]  rr_winner;
  logic [ID_W-1:0]  rr_idx;

  assign granted = (state_q == ST_GRANT);

  // NumReq is a power of two, so the index add wraps modulo NumReq for free;
  // k == NumReq lands back on last_q, giving it the lowest priority.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NumReq; k++) begin
      rr_idx = last_q + ID_W'(k);
      if (!rr_found && req_val_i[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  always_comb begin
    grant_o        = '0;
    req_rdy_o      = '0;
    fifo_din_o     = '0;
    fifo_din_val_o = 1'b0;
    if (granted) begin
      grant_o[gnt_id_q]   = 1'b1;
      req_rdy_o[gnt_id_q] = fifo_din_rdy_i;
      fifo_din_o          = req_data_i[gnt_id_q*DataWidth +: DataWidth];
      fifo_din_val_o      = req_val_i[gnt_id_q];
    end
  end

  assign beat       = fifo_din_val_o & fifo_din_rdy_i;
  assign grant_id_o = granted ? gnt_id_q : '0;
  assign beat_cnt_o = cnt_q;

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          state_d  = ST_GRANT;
          gnt_id_d = rr_winner;
          cnt_d    = '0;
        end
      end
      ST_GRANT: begin
        // Withdrawal or the final beat of a burst both hand the slot back.
        if (!req_val_i[gnt_id_q] || (beat && (cnt_q == LAST_BEAT))) begin
          state_d = ST_IDLE;
          last_d  = gnt_id_q;
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= '0;
      last_q   <= RST_LAST;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter: directed + randomized bench with a behavioural model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]  val;
  logic           frdy;
  logic [NR-1:0]  req_rdy;
  logic [DW-1:0]  din;
  logic           din_val;
  logic [NR-1:0]  grant;
  logic [1:0]     grant_id;
  logic [2:0]     beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner is the granted requester index, -1 when nobody holds the port.
  int m_owner;
  int m_beats;
  int m_last;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .MaxBurst(MB)) dut (
    .clk_i(clk), .arst_ni(arst_n), .req_data_i(data), .req_val_i(val),
    .req_rdy_o(req_rdy), .fifo_din_o(din), .fifo_din_val_o(din_val),
    .fifo_din_rdy_i(frdy), .grant_o(grant), .grant_id_o(grant_id),
    .beat_cnt_o(beat_cnt)
  );

  function automatic logic [3:0] e_grant();
    if (m_owner < 0) return 4'b0;
    return 4'(1 << m_owner);
  endfunction

  function automatic logic [1:0] e_id();
    if (m_owner < 0) return 2'd0;
    return 2'(m_owner);
  endfunction

  function automatic logic [3:0] e_rdy();
    if (m_owner < 0 || !frdy) return 4'b0;
    return 4'(1 << m_owner);
  endfunction

  function automatic logic e_dv();
    if (m_owner < 0) return 1'b0;
    return val[m_owner];
  endfunction

  function automatic logic [DW-1:0] e_din();
    if (m_owner < 0) return '0;
    return data[m_owner*DW +: DW];
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = NR - 1;
  endtask

  task automatic model_step();
    int c;
    bit found;
    if (!arst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && val[c]) begin
          found   = 1;
          m_owner = c;
          m_beats = 0;
        end
      end
    end else if (!val[m_owner] || (frdy && m_beats == MB - 1)) begin
      m_last  = m_owner;
      m_owner = -1;
      m_beats = 0;
    end else if (frdy) begin
      m_beats++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    arst_n = 1'b0;
    val    = '0;
    frdy   = 1'b0;
    #1;
    model_reset();
    adv();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    val    = 4'hF;
    frdy   = 1'b1;
    data   = {$urandom, $urandom};
    #1;
    model_reset();
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    n_cmp++; if (beat_cnt !== 3'd0) begin n_err++; $display("FAIL rst_beat got=%0d exp=0", beat_cnt); end
    n_cmp++; if (din_val !== 1'b0) begin n_err++; $display("FAIL rst_din_val got=%b exp=0", din_val); end
    n_cmp++; if (req_rdy !== 4'b0) begin n_err++; $display("FAIL rst_req_rdy got=%b exp=0000", req_rdy); end
    n_cmp++; if (din !== 16'h0) begin n_err++; $display("FAIL rst_din got=%h exp=0000", din); end
    adv();
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL rst_hold_grant got=%b exp=0000", grant); end
    arst_n = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL rst_release_grant got=%b exp=0000", grant); end
    adv();
    #1;
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rst_first_arb got=%b exp=0001", grant); end
  endtask

  task automatic test_priority();
    int starts[$];
    int exp_order[5];
    int gcycles;
    logic [3:0] prev;
    exp_order = '{0, 1, 2, 3, 0};
    gcycles = 0;
    apply_reset();
    val  = 4'hF;
    frdy = 1'b1;
    data = {$urandom, $urandom};
    prev = 4'b0;
    for (int c = 0; c < 25; c++) begin
      #1;
      n_cmp++; if (grant !== e_grant()) begin n_err++; $display("FAIL prio_grant cyc=%0d got=%b exp=%b", c, grant, e_grant()); end
      n_cmp++; if (beat_cnt !== 3'(m_beats)) begin n_err++; $display("FAIL prio_beat cyc=%0d got=%0d exp=%0d", c, beat_cnt, m_beats); end
      if (grant != 4'b0 && prev == 4'b0) starts.push_back(int'(grant_id));
      if (grant != 4'b0) gcycles++;
      prev = grant;
      adv();
    end
    n_cmp++; if (starts.size() != 5) begin n_err++; $display("FAIL prio_num_grants got=%0d exp=5", starts.size()); end
    n_cmp++; if (gcycles != 20) begin n_err++; $display("FAIL prio_grant_cycles got=%0d exp=20", gcycles); end
    for (int i = 0; i < 5 && i < starts.size(); i++) begin
      n_cmp++; if (starts[i] != exp_order[i]) begin n_err++; $display("FAIL prio_order idx=%0d got=%0d exp=%0d", i, starts[i], exp_order[i]); end
    end
  endtask

  task automatic test_burst_limit();
    logic [3:0] tg [12];
    logic [2:0] tb_ [12];
    tg  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4};
    tb_ = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
    apply_reset();
    val  = 4'b0100;
    frdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      data = {$urandom, $urandom};
      #1;
      n_cmp++; if (grant !== tg[c]) begin n_err++; $display("FAIL burst_grant cyc=%0d got=%b exp=%b", c, grant, tg[c]); end
      n_cmp++; if (beat_cnt !== tb_[c]) begin n_err++; $display("FAIL burst_beat cyc=%0d got=%0d exp=%0d", c, beat_cnt, tb_[c]); end
      adv();
    end
  endtask

  task automatic test_early_release();
    logic [3:0] tg [6];
    logic [2:0] tb_ [6];
    logic       tdv [6];
    tg  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4};
    tb_ = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    tdv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    val  = 4'b0010;
    frdy = 1'b1;
    data = {$urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      if (c == 3) val = 4'b1101;
      #1;
      n_cmp++; if (grant !== tg[c]) begin n_err++; $display("FAIL early_grant cyc=%0d got=%b exp=%b", c, grant, tg[c]); end
      n_cmp++; if (beat_cnt !== tb_[c]) begin n_err++; $display("FAIL early_beat cyc=%0d got=%0d exp=%0d", c, beat_cnt, tb_[c]); end
      n_cmp++; if (din_val !== tdv[c]) begin n_err++; $display("FAIL early_din_val cyc=%0d got=%b exp=%b", c, din_val, tdv[c]); end
      adv();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words [10];
    logic [DW-1:0] rx[$];
    int  sent;
    bit  bp_beat;
    for (int i = 0; i < 10; i++) words[i] = 16'($urandom);
    sent = 0;
    apply_reset();
    val = 4'b0001;
    for (int c = 0; c < 14; c++) begin
      frdy = !(c >= 3 && c <= 7);
      data = {$urandom, $urandom};
      data[DW-1:0] = words[sent];
      #1;
      if (din_val && frdy) rx.push_back(din);
      if (c >= 3 && c <= 7) begin
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL bp_grant cyc=%0d got=%b exp=0001", c, grant); end
        n_cmp++; if (beat_cnt !== 3'd2) begin n_err++; $display("FAIL bp_beat cyc=%0d got=%0d exp=2", c, beat_cnt); end
        n_cmp++; if (din !== words[2]) begin n_err++; $display("FAIL bp_din cyc=%0d got=%h exp=%h", c, din, words[2]); end
        n_cmp++; if (req_rdy !== 4'b0) begin n_err++; $display("FAIL bp_req_rdy cyc=%0d got=%b exp=0000", c, req_rdy); end
      end
      bp_beat = (m_owner == 0) && val[0] && frdy;
      adv();
      if (bp_beat) sent++;
    end
    n_cmp++; if (rx.size() != 7) begin n_err++; $display("FAIL bp_rx_count got=%0d exp=7", rx.size()); end
    for (int i = 0; i < 7 && i < rx.size(); i++) begin
      n_cmp++; if (rx[i] !== words[i]) begin n_err++; $display("FAIL bp_rx_data idx=%0d got=%h exp=%h", i, rx[i], words[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    val  = 4'b1000;
    frdy = 1'b1;
    data = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) adv();
    #1;
    n_cmp++; if (beat_cnt !== 3'd2 || grant !== 4'b1000) begin n_err++; $display("FAIL mid_pre got=%b/%0d exp=1000/2", grant, beat_cnt); end
    arst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (grant !== 4'b0 || grant_id !== 2'd0) begin n_err++; $display("FAIL mid_grant got=%b/%0d exp=0000/0", grant, grant_id); end
    n_cmp++; if (beat_cnt !== 3'd0 || din_val !== 1'b0) begin n_err++; $display("FAIL mid_beat got=%0d/%b exp=0/0", beat_cnt, din_val); end
    n_cmp++; if (req_rdy !== 4'b0 || din !== 16'h0) begin n_err++; $display("FAIL mid_data got=%b/%h exp=0000/0000", req_rdy, din); end
    adv();
    val    = 4'b1001;
    arst_n = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL mid_idle got=%b exp=0000", grant); end
    adv();
    #1;
    n_cmp++; if (grant !== 4'b0001 || beat_cnt !== 3'd0) begin n_err++; $display("FAIL mid_regrant got=%b/%0d exp=0001/0", grant, beat_cnt); end
  endtask

  task automatic test_wrap();
    apply_reset();
    val  = 4'b1000;
    frdy = 1'b0;
    data = {$urandom, $urandom};
    adv();
    #1;
    n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wrap_g3 got=%b exp=1000", grant); end
    val = 4'b0000;
    adv();
    val = 4'b1001;
    #1;
    n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL wrap_idle got=%b exp=0000", grant); end
    adv();
    #1;
    n_cmp++; if (grant !== 4'b0001 || grant_id !== 2'd0) begin n_err++; $display("FAIL wrap_g0 got=%b/%0d exp=0001/0", grant, grant_id); end
  endtask

  task automatic test_random();
    apply_reset();
    val = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) val = 4'($urandom);
      frdy = ($urandom_range(0, 3) != 0);
      data = {$urandom, $urandom};
      #1;
      n_cmp++; if (grant !== e_grant()) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, grant, e_grant()); end
      n_cmp++; if (grant_id !== e_id()) begin n_err++; $display("FAIL rnd_grant_id cyc=%0d got=%0d exp=%0d", c, grant_id, e_id()); end
      n_cmp++; if (beat_cnt !== 3'(m_beats)) begin n_err++; $display("FAIL rnd_beat cyc=%0d got=%0d exp=%0d", c, beat_cnt, m_beats); end
      n_cmp++; if (req_rdy !== e_rdy()) begin n_err++; $display("FAIL rnd_req_rdy cyc=%0d got=%b exp=%b", c, req_rdy, e_rdy()); end
      n_cmp++; if (din_val !== e_dv()) begin n_err++; $display("FAIL rnd_din_val cyc=%0d got=%b exp=%b", c, din_val, e_dv()); end
      n_cmp++; if (din !== e_din()) begin n_err++; $display("FAIL rnd_din cyc=%0d got=%h exp=%h", c, din, e_din()); end
      n_cmp++; if ($countones(grant) > 1 || beat_cnt > 3'(MB - 1)) begin n_err++; $display("FAIL rnd_invariant cyc=%0d grant=%b beat=%0d", c, grant, beat_cnt); end
      adv();
    end
  endtask

  initial begin
    arst_n = 1'b0;
    val    = '0;
    frdy   = 1'b0;
    data   = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_priority();
    test_burst_limit();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 16, meaning width of one data beat.
REQ-002 SHALL have parameter NumReq, default 4, meaning number of requesters (power of two, >=2).
REQ-003 SHALL have parameter MaxBurst, default 4, meaning maximum beats per grant (>=1).
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port arst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_data_i  input  NumReq*DataWidth  requester data, requester k in bits [k*DataWidth +: DataWidth].
REQ-007 SHALL have port req_val_i  input  NumReq  per-requester valid.
REQ-008 SHALL have port req_rdy_o  output  NumReq  per-requester ready.
REQ-009 SHALL have port fifo_din_o  output  DataWidth  data to the FIFO write port.
REQ-010 SHALL have port fifo_din_val_o  output  1  valid to the FIFO write port.
REQ-011 SHALL have port fifo_din_rdy_i  input  1  ready from the FIFO write port (FIFO not full).
REQ-012 SHALL have port grant_o  output  NumReq  one-hot current grant, all-zero when idle.
REQ-013 SHALL have port grant_id_o  output  $clog2(NumReq)  index of the granted requester, 0 when idle.
REQ-014 SHALL have port beat_cnt_o  output  $clog2(MaxBurst+1)  beats transferred in the current grant.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE with any req_val_i bit set, SHALL select the winner round-robin, searching from (last_winner+1) mod NumReq upward with wrap-around, and SHALL enter GRANT on the next edge with grant_o/grant_id_o registered to that winner.
REQ-017 In IDLE with req_val_i all zero, SHALL stay in IDLE; last_winner is unchanged.
REQ-018 Arbitration latency SHALL be exactly one cycle, from req_val_i sampled high in IDLE to grant_o asserted.
REQ-019 In GRANT for winner g: fifo_din_o = data of g; fifo_din_val_o = req_val_i[g]; req_rdy_o[g] = fifo_din_rdy_i; all other req_rdy_o bits 0. This path SHALL be combinational, with no added latency.
REQ-020 In IDLE: fifo_din_val_o = 0, req_rdy_o = 0, fifo_din_o = 0.
REQ-021 A beat SHALL occur when fifo_din_val_o && fifo_din_rdy_i; each beat increments beat_cnt_o by 1.
REQ-022 GRANT SHALL release to IDLE on the edge where a beat occurs and beat_cnt_o == MaxBurst-1 (burst limit).
REQ-023 GRANT SHALL release to IDLE on any edge where req_val_i[g] is 0 (requester done or withdrawn), including zero-beat grants.
REQ-024 GRANT SHALL hold with no beat while req_val_i[g]=1 and fifo_din_rdy_i=0 (FIFO full); there is no timeout, and the grant is not released.
REQ-025 On release, SHALL set last_winner = g and clear beat_cnt_o to 0; grant_o SHALL be all-zero for at least one cycle (IDLE bubble) before any new grant.
REQ-026 Changes on non-granted req_val_i/req_data_i during GRANT SHALL NOT affect outputs or state.
REQ-027 The block SHALL never present more than one grant_o bit set, and SHALL never assert req_rdy_o for a non-granted requester.
REQ-028 beat_cnt_o SHALL never exceed MaxBurst-1 while observable.

Reset
REQ-029 While arst_ni=0: state = IDLE, grant_o = 0, grant_id_o = 0, beat_cnt_o = 0, fifo_din_val_o = 0, req_rdy_o = 0, fifo_din_o = 0, last_winner = NumReq-1 (so requester 0 has first priority).
REQ-030 Reset assertion mid-GRANT SHALL abort the burst immediately and asynchronously; a partially sent burst is not resumed.
REQ-031 After deassertion, the first arbitration SHALL occur on the first rising edge with arst_ni=1.

Verification
REQ-032 SHALL cover post-reset priority: req_val_i=4'b1111, fifo_din_rdy_i=1 -> grants in order 0,1,2,3,0, each lasting 4 beats with a 1-cycle IDLE gap.
REQ-033 SHALL cover the burst limit: only req 2 valid, continuous -> 4 beats, 1 idle cycle, re-grant to 2; beat_cnt_o sequence 0,1,2,3.
REQ-034 SHALL cover early release: req 1 valid for 2 beats, then drops -> release after beat 2, last_winner=1, next search starts at 2.
REQ-035 SHALL cover FIFO backpressure: fifo_din_rdy_i=0 for 5 cycles mid-burst -> grant held, beat_cnt_o frozen, fifo_din_o stable, no data lost.
REQ-036 SHALL cover reset mid-burst: arst_ni low at beat 2 of req 3 -> all outputs 0 immediately, and the next grant goes to req 0 if valid.
REQ-037 SHALL cover the wrap-around search: last_winner=3 with only req 0 and req 3 valid -> grant req 0.
